// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM states, port ownership and the
// registered copy of the granted bus request.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DRAIN} arb_state_e;

    typedef enum logic {OWN_IF, OWN_MEM} arb_owner_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_req_t;

    localparam logic [3:0] FETCH_STRB = 4'hF;

    // Fetches are always full-word reads.
    function automatic bus_req_t fetch_req(input logic [31:0] addr);
        bus_req_t r;
        r.we    = 1'b0;
        r.addr  = addr;
        r.wdata = '0;
        r.wstrb = FETCH_STRB;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Fetch starvation counter for mem_port_arbiter; the module exists only when
// MEMARB_AGING_EN is defined.
`ifdef MEMARB_AGING_EN
module arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic arb,
    input  logic if_won,
    output logic starve
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] count;

    // Counts arbitrations fetch lost while still requesting; saturates at 15.
    always_ff @(posedge clk) begin
        if (rst || !if_req) begin
            count <= '0;
        end else if (arb) begin
            if (if_won)
                count <= '0;
            else if (count != 4'hF)
                count <= count + 4'd1;
        end
    end

    assign starve = (count >= LIMIT);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and MEM stages of the br32 pipeline.
// Define MEMARB_AGING_EN to let a starved fetch win after STARVE_LIMIT losses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        mem_stall,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    arb_state_e state, state_nxt;
    bus_req_t   held, held_nxt;
    bus_req_t   mem_attr, win_attr, cur;
    arb_owner_e winner;
    logic       any_req;
    logic       starve;

    assign any_req  = if_req || mem_req;
    assign winner   = (mem_req && !(if_req && starve)) ? OWN_MEM : OWN_IF;
    assign mem_attr = '{mem_we, mem_addr, mem_wdata, mem_wstrb};
    assign win_attr = (winner == OWN_MEM) ? mem_attr : fetch_req(if_addr);

`ifdef MEMARB_AGING_EN
    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .if_req(if_req),
        .arb   ((state == IDLE) && any_req),
        .if_won(winner == OWN_IF),
        .starve(starve)
    );
`else
    logic [3:0] unused_limit;
    assign unused_limit = 4'(STARVE_LIMIT);
    assign starve       = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            held  <= '0;
        end else begin
            state <= state_nxt;
            held  <= held_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        held_nxt  = held;
        cur       = '0;
        bus_valid = 1'b0;
        if_ack    = 1'b0;
        mem_ack   = 1'b0;
        // Outputs are forced quiet while reset is held.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus_valid = 1'b1;
                        cur       = win_attr;
                        if (bus_ready) begin
                            if_ack  = (winner == OWN_IF) && !if_flush;
                            mem_ack = (winner == OWN_MEM);
                        end else begin
                            held_nxt = win_attr;
                            if (winner == OWN_MEM)
                                state_nxt = BUSY_MEM;
                            else
                                state_nxt = if_flush ? DRAIN : BUSY_IF;
                        end
                    end
                end
                BUSY_IF: begin
                    bus_valid = 1'b1;
                    cur       = held;
                    if (bus_ready) begin
                        if_ack    = !if_flush;
                        state_nxt = IDLE;
                    end else if (if_flush) begin
                        state_nxt = DRAIN;
                    end
                end
                BUSY_MEM: begin
                    bus_valid = 1'b1;
                    cur       = held;
                    if (bus_ready) begin
                        mem_ack   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                DRAIN: begin
                    // The cancelled fetch still owns the bus until memory completes it.
                    bus_valid = 1'b1;
                    cur       = held;
                    if (bus_ready)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus_we    = cur.we;
    assign bus_addr  = cur.addr;
    assign bus_wdata = cur.wdata;
    assign bus_wstrb = cur.wstrb;

    assign if_rdata  = if_ack  ? bus_rdata : '0;
    assign mem_rdata = mem_ack ? bus_rdata : '0;
    assign if_stall  = if_req  && !if_ack;
    assign mem_stall = mem_req && !mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// every ack and the bus contents; a negedge monitor compares them.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LIMIT = 4;
`ifdef MEMARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0, if_ack, if_stall;
    logic [31:0] if_addr = '0, if_rdata;
    logic        mem_req = 1'b0, mem_we = 1'b0, mem_ack, mem_stall;
    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
    logic [3:0]  mem_wstrb = '0;
    logic        bus_valid, bus_we, bus_ready = 1'b0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
    logic [3:0]  bus_wstrb;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    typedef struct {
        bit          is_mem;
        int          cyc;
        logic [31:0] rdata;
        bit          we;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Requester and memory-responder knobs.
    bit          if_pend = 0, mem_pend = 0;
    bus_req_t    if_txn = '0, mem_txn = '0;
    int          p_if = 0, p_mem = 0, p_flush = 0, wait_mode = 0;
    bit          flush_once = 0;
    bit          rdata_fixed_en = 0;
    logic [31:0] rdata_fixed = '0;

    // Reference model: one transaction in flight, wait count chosen per transaction.
    bit       m_busy = 0, m_is_mem = 0, m_flushed = 0;
    int       m_age = 0, m_wait = 0, m_starve = 0;
    bus_req_t m_cur = '0;
    bit       exp_valid = 0;
    bus_req_t exp_bus = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_eval();
        exp_t e;
        exp_valid = 1'b0;
        exp_bus   = '0;
        if (rst) begin
            m_busy = 0; m_flushed = 0; m_starve = 0;
            return;
        end
        if (!m_busy && (if_req || mem_req)) begin
            m_is_mem = mem_req && !(AGING && if_req && m_starve >= LIMIT);
            if (m_is_mem) begin
                m_cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
                if (if_req && m_starve < 15) m_starve++;
            end else begin
                m_cur = '{we: 1'b0, addr: if_addr, wdata: 32'h0, wstrb: 4'hF};
                m_starve = 0;
            end
            m_busy = 1; m_age = 0; m_flushed = 0;
        end
        if (m_busy) begin
            exp_valid = 1'b1;
            exp_bus   = m_cur;
            if (!m_is_mem && if_flush) m_flushed = 1;
            if (bus_ready) begin
                if (!(m_flushed && !m_is_mem)) begin
                    e.is_mem = m_is_mem; e.cyc = cyc; e.rdata = bus_rdata; e.we = m_cur.we;
                    sb.push_back(e);
                    if (m_is_mem) mem_pend = 0; else if_pend = 0;
                end
                m_busy = 0;
            end else begin
                m_age++;
            end
        end
        if (if_flush && if_req) if_pend = 0;
        if (!if_req) m_starve = 0;
    endtask

    task automatic step(input bit do_rst);
        logic [31:0] r;
        @(posedge clk); #1;
        cyc++;
        if (do_rst) begin
            if_pend = 0; mem_pend = 0;
        end else begin
            if (!if_pend && $urandom_range(99) < p_if) begin
                r = $urandom; r[1:0] = 2'b00;
                if_txn = '{we: 1'b0, addr: r, wdata: 32'h0, wstrb: 4'hF};
                if_pend = 1;
            end
            if (!mem_pend && $urandom_range(99) < p_mem) begin
                mem_txn.we    = 1'($urandom_range(1));
                mem_txn.addr  = $urandom;
                mem_txn.wdata = $urandom;
                mem_txn.wstrb = 4'($urandom_range(15));
                mem_pend = 1;
            end
        end
        rst       = do_rst;
        if_req    = if_pend;
        if_addr   = if_txn.addr;
        if_flush  = !do_rst && if_pend && (flush_once || $urandom_range(99) < p_flush);
        flush_once = 0;
        mem_req   = mem_pend;
        mem_we    = mem_txn.we;
        mem_addr  = mem_txn.addr;
        mem_wdata = mem_txn.wdata;
        mem_wstrb = mem_txn.wstrb;
        if (!m_busy) m_wait = (wait_mode < 0) ? int'($urandom_range(3)) : wait_mode;
        bus_ready = ((m_busy ? m_age : 0) == m_wait);
        bus_rdata = rdata_fixed_en ? rdata_fixed : $urandom;
        model_eval();
    endtask

    always @(negedge clk) begin
        bit   e_if, e_mem;
        exp_t e;
        e_if = 0; e_mem = 0;
        e = '{default: 0};
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            e_if = !e.is_mem; e_mem = e.is_mem;
        end
        check("if_ack", if_ack, e_if);
        check("mem_ack", mem_ack, e_mem);
        check("bus_valid", bus_valid, exp_valid);
        if (exp_valid || rst) begin
            check("bus_we", bus_we, exp_bus.we);
            check("bus_addr", bus_addr, exp_bus.addr);
            check("bus_wdata", bus_wdata, exp_bus.wdata);
            check("bus_wstrb", bus_wstrb, exp_bus.wstrb);
        end
        check("if_stall", if_stall, if_req && !e_if);
        check("mem_stall", mem_stall, mem_req && !e_mem);
        if (e_if) check("if_rdata", if_rdata, e.rdata);
        if (e_mem && !e.we) check("mem_rdata", mem_rdata, e.rdata);
        if (rst) begin
            check("rst_if_rdata", if_rdata, 0);
            check("rst_mem_rdata", mem_rdata, 0);
        end
    end

    initial begin
        repeat (3) step(1);

        // Zero-wait fetch of 0x100 returning 0xDEADBEEF, then a back-to-back one.
        wait_mode = 0;
        rdata_fixed_en = 1; rdata_fixed = 32'hDEADBEEF;
        if_pend = 1; if_txn = '{we: 1'b0, addr: 32'h100, wdata: 32'h0, wstrb: 4'hF};
        step(0);
        rdata_fixed_en = 0;
        if_pend = 1; if_txn.addr = 32'h104;
        step(0);
        step(0);

        // 2-wait: MEM write and fetch raised together.
        wait_mode = 2;
        if_pend = 1; if_txn.addr = 32'h200;
        mem_pend = 1; mem_txn = '{we: 1'b1, addr: 32'h40, wdata: 32'h12345678, wstrb: 4'h3};
        repeat (8) step(0);

        // 3-wait fetch cancelled in its second cycle.
        wait_mode = 3;
        if_pend = 1; if_txn.addr = 32'h300;
        step(0);
        flush_once = 1;
        step(0);
        repeat (4) step(0);

        // Flush coincident with bus_ready in BUSY_IF, then in zero-wait IDLE.
        wait_mode = 2;
        if_pend = 1; if_txn.addr = 32'h304;
        repeat (2) step(0);
        flush_once = 1;
        step(0);
        step(0);
        wait_mode = 0;
        if_pend = 1; if_txn.addr = 32'h308;
        flush_once = 1;
        step(0);
        step(0);

        // Both requesters continuous at zero wait.
        p_if = 100; p_mem = 100;
        repeat (25) step(0);
        p_if = 0; p_mem = 0;
        repeat (4) step(0);

        // Reset while a MEM read is outstanding, then a fresh fetch.
        wait_mode = 3;
        mem_pend = 1; mem_txn = '{we: 1'b0, addr: 32'h80, wdata: 32'h0, wstrb: 4'hF};
        repeat (2) step(0);
        step(1);
        repeat (2) step(0);
        wait_mode = 1;
        if_pend = 1; if_txn.addr = 32'h400;
        repeat (3) step(0);

        // Randomized traffic with random wait states and flushes.
        p_if = 50; p_mem = 40; p_flush = 6; wait_mode = -1;
        repeat (3000) step(0);
        p_if = 0; p_mem = 0; p_flush = 0;
        repeat (30) step(0);

        @(negedge clk); #1;
        check("scoreboard_empty", sb.size(), 0);
        check("requests_served", {if_pend, mem_pend}, 2'b00);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
